// File: rtl/line_fetch_ctrl_if.sv
// PSRAM read-port and line-buffer write-port bundle for line_fetch_ctrl.
// master = fetch controller, slave = PSRAM/line-buffer side.
interface line_fetch_ctrl_if #(
  parameter int ADDR_W = 22
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [9:0]        wr_addr;
  logic [23:0]       wr_data;
  logic              wr_en;

  modport master (
    output rd_req, rd_addr, wr_addr, wr_data, wr_en,
    input  rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_addr, wr_data, wr_en,
    output rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/line_fetch_ctrl.sv
// Refills the display line buffer from PSRAM once per scan line (PSRAM clock domain).
// Build macro LINE_FETCH_TESTPAT_EN adds a `testpat` input and an internal pattern source.
module line_fetch_ctrl #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 480,
  parameter int BURST_LEN   = 16,
  parameter int LINE_STRIDE = 800,
  parameter int FB_BASE     = 0,
  parameter int ADDR_W      = 22
) (
  input  logic              clk_psram,
  input  logic              rst,
  input  logic              line_request,
  input  logic [9:0]        y_pos,
`ifdef LINE_FETCH_TESTPAT_EN
  input  logic              testpat,
`endif
  line_fetch_ctrl_if.master bus,
  output logic              busy,
  output logic              line_done,
  output logic [7:0]        overrun_cnt
);

  localparam int NBURST = H_RES / BURST_LEN;
  localparam int BCW    = $clog2(NBURST + 1);
  localparam int BTW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [9:0]        line_q, line_d;
  logic [9:0]        pix_q, pix_d;
  logic [9:0]        pend_y_q, pend_y_d;
  logic              pending_q, pending_d;
  logic [BCW-1:0]    burst_q, burst_d;
  logic [BTW-1:0]    beat_q, beat_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [9:0]        wr_addr_q;
  logic [23:0]       wr_data_q;
  logic              busy_q, line_done_q;
  logic              start;
  logic [9:0]        start_y;
  logic              beat_v;
  logic [23:0]       beat_pix;
  state_t            refill_st;
  logic              unused_rd_hi;
`ifdef LINE_FETCH_TESTPAT_EN
  logic              tp_q, tp_d;
`endif

  assign unused_rd_hi = ^bus.rd_data[31:24];

  function automatic logic [9:0] next_line(input logic [9:0] y);
    logic [10:0] n;
    n = {1'b0, y} + 11'd1;
    return (n == 11'(V_RES)) ? 10'd0 : n[9:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    pix_d     = pix_q;
    pend_y_d  = pend_y_q;
    pending_d = pending_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    ovr_d     = ovr_q;
    wr_en_d   = 1'b0;
    start     = 1'b0;
    start_y   = y_pos;
    beat_v    = bus.rd_valid;
    beat_pix  = bus.rd_data[23:0];
    refill_st = CMD;
`ifdef LINE_FETCH_TESTPAT_EN
    tp_d = tp_q;
    if (tp_q) begin
      // Generator replaces PSRAM beats: one pixel every cycle, no commands.
      beat_v    = 1'b1;
      beat_pix  = {pix_q[7:0], line_q[7:0], pix_q[7:0] ^ line_q[7:0]};
      refill_st = DATA;
    end
`endif

    case (state_q)
      IDLE: begin
        if (line_request || pending_q) begin
          start     = 1'b1;
          start_y   = line_request ? y_pos : pend_y_q;
          pending_d = 1'b0;
        end
      end
      CMD: begin
        if (bus.rd_ack) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (beat_v) begin
          wr_en_d = 1'b1;
          pix_d   = pix_q + 10'd1;
          beat_d  = beat_q + BTW'(1);
          if (beat_q == BTW'(BURST_LEN - 1)) begin
            burst_d = burst_q + BCW'(1);
            state_d = (int'(burst_d) < NBURST) ? refill_st : DONE;
          end
        end
      end
      DONE: begin
        if (pending_q) begin
          start     = 1'b1;
          start_y   = pend_y_q;
          pending_d = 1'b0;
        end else if (line_request) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request landing in DONE replaces the consumed pending slot without counting as overrun.
    if (line_request && (state_q != IDLE)) begin
      if (pending_q) begin
        pending_d = 1'b1;
        pend_y_d  = y_pos;
        if ((state_q != DONE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
      end else if (state_q != DONE) begin
        pending_d = 1'b1;
        pend_y_d  = y_pos;
      end
    end

    if (start) begin
      line_d  = next_line(start_y);
      burst_d = '0;
      pix_d   = '0;
      beat_d  = '0;
      state_d = CMD;
`ifdef LINE_FETCH_TESTPAT_EN
      tp_d = testpat;
      if (testpat) state_d = DATA;
`endif
    end

    addr_d = ADDR_W'(FB_BASE + int'(line_d) * LINE_STRIDE + int'(burst_d) * BURST_LEN);
  end

  always_ff @(posedge clk_psram) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      pix_q       <= '0;
      pend_y_q    <= '0;
      pending_q   <= 1'b0;
      burst_q     <= '0;
      beat_q      <= '0;
      ovr_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
`ifdef LINE_FETCH_TESTPAT_EN
      tp_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      pix_q       <= pix_d;
      pend_y_q    <= pend_y_d;
      pending_q   <= pending_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      ovr_q       <= ovr_d;
      rd_req_q    <= (state_d == CMD);
      if (state_d == CMD) rd_addr_q <= addr_d;
      wr_en_q     <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= pix_q;
        wr_data_q <= beat_pix;
      end
      busy_q      <= (state_d != IDLE);
      line_done_q <= (state_q == DONE);
`ifdef LINE_FETCH_TESTPAT_EN
      tp_q        <= tp_d;
`endif
    end
  end

  assign bus.rd_req   = rd_req_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign line_done    = line_done_q;
  assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Self-checking bench for line_fetch_ctrl: PSRAM responder, scoreboard monitor, directed line fetches.
module tb_line_fetch_ctrl;
  localparam int H_RES = 800, V_RES = 480, BURST_LEN = 16, LINE_STRIDE = 800;
  localparam int FB_BASE = 0, ADDR_W = 22;
  localparam int NB = H_RES / BURST_LEN;

  logic       clk_psram = 1'b0;
  logic       rst = 1'b1;
  logic       line_request = 1'b0;
  logic       testpat = 1'b0;
  logic [9:0] y_pos = '0;
  logic       busy, line_done;
  logic [7:0] overrun_cnt;

  line_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus_if();

  line_fetch_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .BURST_LEN(BURST_LEN),
    .LINE_STRIDE(LINE_STRIDE), .FB_BASE(FB_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clk_psram(clk_psram),
    .rst(rst),
    .line_request(line_request),
    .y_pos(y_pos),
`ifdef LINE_FETCH_TESTPAT_EN
    .testpat(testpat),
`endif
    .bus(bus_if),
    .busy(busy),
    .line_done(line_done),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk_psram = ~clk_psram;

  typedef struct {int pix; logic [23:0] data; int cyc;} beat_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  beat_t beat_q[$];
  logic [ADDR_W-1:0] acc_q[$];
  logic [ADDR_W-1:0] acc_log[$];
  int exp_lines[$];
  int k_burst = 0, cur_line = 0;
  int cfg_hold = 1;
  bit cfg_gap = 1'b0;
  int stray_n = 0;
  int line_writes = 0, wr_total = 0, done_cnt = 0, dup_cnt = 0;
  int req_cycles = 0, req_run = 0, req_min = 1000000, req_max = 0, last_wr_cyc = -10;
  bit seen[H_RES];
  bit tp_mode = 1'b0;
  int tp_line = 0, tp_pix = 0;
  logic [23:0] pix5_data = '0;
  logic pulse_rdreq, pulse_busy;
  logic [ADDR_W-1:0] pulse_addr;
  int beats_left = 0, beat_i = 0, req_cnt = 0, pix_ctr = 0;
  bit gap_ph = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic longint log_at(input int i);
    if (i < acc_log.size()) return longint'(acc_log[i]);
    return -1;
  endfunction

  // PSRAM responder: acks after cfg_hold cycles of rd_req, returns BURST_LEN beats.
  initial begin
    logic [23:0] d24;
    bus_if.rd_ack = 1'b0; bus_if.rd_valid = 1'b0; bus_if.rd_data = '0;
    forever begin
      @(negedge clk_psram);
      bus_if.rd_ack = 1'b0; bus_if.rd_valid = 1'b0; bus_if.rd_data = '0;
      if (rst) begin
        beats_left = 0; req_cnt = 0; gap_ph = 1'b0; pix_ctr = 0;
      end else begin
        if (stray_n > 0) begin
          bus_if.rd_valid = 1'b1; bus_if.rd_data = $urandom; stray_n--;
        end else if (beats_left > 0) begin
          if (cfg_gap && gap_ph) gap_ph = 1'b0;
          else begin
            gap_ph = cfg_gap;
            d24 = 24'(int'(cur_addr) + beat_i) ^ 24'h3C5A00;
            bus_if.rd_valid = 1'b1;
            bus_if.rd_data = {8'($urandom), d24};
            beat_q.push_back('{pix_ctr, d24, cyc});
            pix_ctr = (pix_ctr + 1) % H_RES;
            beat_i++; beats_left--;
          end
        end
        if (bus_if.rd_req) begin
          req_cnt++;
          if (req_cnt >= cfg_hold) begin
            bus_if.rd_ack = 1'b1;
            acc_q.push_back(bus_if.rd_addr);
            cur_addr = bus_if.rd_addr;
            beats_left = BURST_LEN; beat_i = 0; req_cnt = 0; gap_ph = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares commands and writes against the line-level model every cycle.
  initial begin
    logic [ADDR_W-1:0] a;
    beat_t b;
    logic [7:0] p8, l8;
    longint exp_a;
    forever begin
      @(posedge clk_psram); cyc++; #1;
      if (rst) continue;
      while (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        acc_log.push_back(a);
        if (k_burst == 0) begin
          chk("line_expected", exp_lines.size() > 0, 1);
          if (exp_lines.size() > 0) cur_line = exp_lines.pop_front();
        end
        exp_a = (longint'(FB_BASE) + longint'(cur_line) * LINE_STRIDE + longint'(k_burst) * BURST_LEN)
                % (longint'(1) << ADDR_W);
        chk("rd_addr", a, exp_a);
        k_burst = (k_burst + 1) % NB;
      end
      if (bus_if.wr_en) begin
        wr_total++; line_writes++;
        if (tp_mode) begin
          p8 = 8'(tp_pix); l8 = 8'(tp_line);
          chk("tp_wr_addr", bus_if.wr_addr, tp_pix);
          chk("tp_wr_data", bus_if.wr_data, {p8, l8, p8 ^ l8});
          tp_pix++;
        end else if (beat_q.size() == 0) begin
          chk("wr_unexpected", bus_if.wr_en, 0);
        end else begin
          b = beat_q.pop_front();
          chk("wr_addr", bus_if.wr_addr, b.pix);
          chk("wr_data", bus_if.wr_data, b.data);
          chk("wr_latency", cyc, b.cyc + 1);
        end
        if (bus_if.wr_addr == 10'd5) pix5_data = bus_if.wr_data;
        if (bus_if.wr_addr < H_RES) begin
          if (seen[bus_if.wr_addr]) dup_cnt++;
          seen[bus_if.wr_addr] = 1'b1;
        end
        if (bus_if.wr_addr == 10'(H_RES - 1)) begin
          last_wr_cyc = cyc;
          foreach (seen[i]) seen[i] = 1'b0;
        end
      end
      if (line_done) begin
        done_cnt++;
        chk("done_latency", cyc, last_wr_cyc + 1);
      end
      if ((bus_if.rd_req || bus_if.wr_en) && !busy) chk("busy_while_active", busy, 1);
      if (bus_if.rd_req) begin
        req_cycles++; req_run++;
      end else if (req_run > 0) begin
        if (req_run < req_min) req_min = req_run;
        if (req_run > req_max) req_max = req_run;
        req_run = 0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_req"}, bus_if.rd_req, 0);
    chk({tag, "_rd_addr"}, bus_if.rd_addr, 0);
    chk({tag, "_wr_en"}, bus_if.wr_en, 0);
    chk({tag, "_wr_addr"}, bus_if.wr_addr, 0);
    chk({tag, "_wr_data"}, bus_if.wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_line_done"}, line_done, 0);
    chk({tag, "_overrun"}, overrun_cnt, 0);
  endtask

  task automatic clear_stats();
    line_writes = 0; done_cnt = 0; dup_cnt = 0;
    req_min = 1000000; req_max = 0;
    acc_log.delete();
    foreach (seen[i]) seen[i] = 1'b0;
  endtask

  task automatic pulse(input int y, input bit tp);
    @(negedge clk_psram);
    line_request = 1'b1; y_pos = 10'(y); testpat = tp;
    @(posedge clk_psram); #1;
    pulse_rdreq = bus_if.rd_req; pulse_busy = busy; pulse_addr = bus_if.rd_addr;
    @(negedge clk_psram);
    line_request = 1'b0; testpat = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) @(posedge clk_psram);
    chk({tag, "_done_in_time"}, done_cnt >= n, 1);
    repeat (3) @(posedge clk_psram);
    #1;
  endtask

  initial begin
    int wr_before, req_before;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk_psram);
    #1;
    check_reset_vals("reset");
    @(negedge clk_psram); rst = 1'b0;
    $display("reset: checks=%0d", checks);

    // y=9 -> line 10, immediate ack and data
    cfg_hold = 1; cfg_gap = 1'b0; clear_stats();
    exp_lines.push_back(10);
    pulse(9, 1'b0);
    chk("t1_rdreq_rise", pulse_rdreq, 1);
    chk("t1_busy_rise", pulse_busy, 1);
    chk("t1_rdaddr_rise", pulse_addr, 8000);
    wait_done("t1", 1, 4000);
    chk("t1_cmds", acc_log.size(), 50);
    chk("t1_first_addr", log_at(0), 8000);
    chk("t1_last_addr", log_at(49), 8784);
    chk("t1_writes", line_writes, 800);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_dups", dup_cnt, 0);
    chk("t1_overrun", overrun_cnt, 0);
    chk("t1_busy_low", busy, 0);
    $display("line y=9: cmds=%0d writes=%0d done=%0d", acc_log.size(), line_writes, done_cnt);

    // y=479 wraps to line 0
    clear_stats();
    exp_lines.push_back(0);
    pulse(479, 1'b0);
    wait_done("t2", 1, 4000);
    chk("t2_first_addr", log_at(0), 0);
    chk("t2_last_addr", log_at(49), 784);
    chk("t2_writes", line_writes, 800);
    $display("line y=479: cmds=%0d writes=%0d done=%0d", acc_log.size(), line_writes, done_cnt);

    // Delayed ack (5 cycles), gapped data
    cfg_hold = 5; cfg_gap = 1'b1; clear_stats();
    exp_lines.push_back(21);
    pulse(20, 1'b0);
    wait_done("t3", 1, 8000);
    chk("t3_req_hold_min", req_min, 5);
    chk("t3_req_hold_max", req_max, 5);
    chk("t3_cmds", acc_log.size(), 50);
    chk("t3_first_addr", log_at(0), 16800);
    chk("t3_writes", line_writes, 800);
    chk("t3_dups", dup_cnt, 0);
    $display("line y=20 slow: cmds=%0d writes=%0d req_hold=%0d..%0d", acc_log.size(), line_writes, req_min, req_max);

    // Three requests during one fetch: newest pending kept, one overrun
    cfg_hold = 1; cfg_gap = 1'b0; clear_stats();
    exp_lines.push_back(31);
    exp_lines.push_back(201);
    pulse(30, 1'b0);
    repeat (100) @(posedge clk_psram);
    pulse(100, 1'b0);
    repeat (100) @(posedge clk_psram);
    pulse(200, 1'b0);
    wait_done("t4", 2, 6000);
    chk("t4_overrun", overrun_cnt, 1);
    chk("t4_done_count", done_cnt, 2);
    chk("t4_cmds", acc_log.size(), 100);
    chk("t4_pending_addr", log_at(50), 160800);
    chk("t4_writes", line_writes, 1600);
    chk("t4_dups", dup_cnt, 0);
    $display("lines y=30+pending: cmds=%0d writes=%0d overrun=%0d", acc_log.size(), line_writes, overrun_cnt);

    // Reset mid-line at pixel 300, then stray beats
    clear_stats();
    exp_lines.push_back(51);
    pulse(50, 1'b0);
    for (int i = 0; i < 2000 && line_writes < 300; i++) @(posedge clk_psram);
    chk("t5_reached_300", line_writes >= 300, 1);
    @(posedge clk_psram); #2;
    rst = 1'b1;
    exp_lines.delete(); beat_q.delete(); acc_q.delete(); k_burst = 0;
    repeat (2) @(posedge clk_psram);
    #2;
    rst = 1'b0;
    wr_before = wr_total;
    stray_n = 4;
    repeat (8) @(posedge clk_psram);
    #1;
    chk("t5_stray_writes", wr_total - wr_before, 0);
    check_reset_vals("t5");
    $display("reset mid-line: writes_before_reset=%0d stray_writes=%0d", line_writes, wr_total - wr_before);

`ifdef LINE_FETCH_TESTPAT_EN
    // Test pattern: y=3 -> line 4, no PSRAM traffic
    clear_stats();
    tp_mode = 1'b1; tp_line = 4; tp_pix = 0;
    req_before = req_cycles;
    pulse(3, 1'b1);
    wait_done("t6", 1, 3000);
    chk("t6_no_rdreq", req_cycles - req_before, 0);
    chk("t6_pix5", pix5_data, 24'h050401);
    chk("t6_writes", line_writes, 800);
    chk("t6_cmds", acc_log.size(), 0);
    tp_mode = 1'b0;
    $display("testpat y=3: writes=%0d pix5=0x%06h", line_writes, pix5_data);
`else
    req_before = req_cycles;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t required completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_fetch_ctrl.md
# line_fetch_ctrl

Sequencer in the PSRAM clock domain that refills the display ping-pong line buffer once per scan line. On each `line_request` pulse it computes the next line's framebuffer address, issues `H_RES/BURST_LEN` burst reads to the PSRAM read port, and streams the returned pixels onto the line-buffer write port (`wr_addr`/`wr_data`/`wr_en`). It sits between the PSRAM controller and the video system, and reports fetch overruns when a line is not finished before the next request.

## Interface
- `H_RES`, 800: pixels per line; must be a multiple of `BURST_LEN` and ≤ 1024.
- `V_RES`, 480: visible lines; the next-line index wraps at this value.
- `BURST_LEN`, 16: pixels per PSRAM read command; power of two.
- `LINE_STRIDE`, 800: framebuffer words per line.
- `FB_BASE`, 0: framebuffer base word address.
- `ADDR_W`, 22: PSRAM word-address width.

Ports:
- `clk_psram`  in  1  PSRAM-domain clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `line_request`  in  1  one-cycle pulse at the end of each displayed line (already synchronized).
- `y_pos`  in  10  current display line; sampled only in the cycle `line_request` is high.
- `rd_req`  out  1  read command valid.
- `rd_addr`  out  ADDR_W  burst start word address.
- `rd_ack`  in  1  command accepted in the cycle `rd_req && rd_ack`.
- `rd_valid`  in  1  read data beat valid.
- `rd_data`  in  32  beat data; pixel is in `[23:0]`, `[31:24]` is ignored.
- `wr_addr`  out  10  line-buffer pixel index.
- `wr_data`  out  24  pixel RGB888.
- `wr_en`  out  1  line-buffer write strobe.
- `busy`  out  1  high from request acceptance until the last pixel is written.
- `line_done`  out  1  one-cycle pulse after the last pixel of a line is written.
- `overrun_cnt`  out  8  saturating count of overruns.

## Operation
- States: `IDLE`, `CMD`, `DATA`, `DONE`.
- `IDLE`: on `line_request` (or a latched `pending`), set `line = (y_pos+1 == V_RES) ? 0 : y_pos+1`, `burst = 0`, `pix = 0`, then go to `CMD`. `busy` goes high.
- `CMD`: `rd_req = 1`, `rd_addr = FB_BASE + line*LINE_STRIDE + burst*BURST_LEN`, truncated to `ADDR_W` bits. On `rd_ack`, deassert `rd_req`, clear the beat counter and go to `DATA`.
- `DATA`: on each `rd_valid`, write `pix` and increment it; after `BURST_LEN` beats, `burst++`. Go to `CMD` if `burst < H_RES/BURST_LEN`, else to `DONE`.
- `DONE`: pulse `line_done` for one cycle and drop `busy`. Go to `IDLE`, or straight to `CMD` with new line setup if `pending` is set.
- `line_request` while `busy`:
  - If `pending` is clear, set `pending` and capture `y_pos`.
  - If `pending` is already set, increment `overrun_cnt` (saturates at 255) and overwrite the captured `y_pos`. Only the newest request is kept.
- `line_request` arriving in the same cycle as `DONE` counts as pending, not as an overrun.
- `rd_valid` in `IDLE` or `CMD` (stray beats) is ignored; nothing is written.
- `y_pos` crosses clock domains but is stable for a whole line and is only sampled with `line_request`. No synchronizer is required.

## Timing
- Reset values (all outputs and state): `rd_req=0`, `rd_addr=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `line_done=0`, `overrun_cnt=0`, `pending=0`, state `IDLE`.
- Reset asserted mid-line aborts immediately; beats arriving after reset is released are dropped.
- `rd_req` is registered and rises one cycle after `line_request`. It stays high until the `rd_ack` cycle and is low in the following cycle.
- Write latency is 1 cycle: `wr_en`, `wr_addr` and `wr_data` are registered from `rd_valid`/`rd_data`.
- `line_done` is asserted one cycle after the final `wr_en`.
- Back-to-back `rd_valid` beats are supported at 1 pixel per cycle.

## Configuration
- `LINE_FETCH_TESTPAT_EN` defined: adds input port `testpat` (1 bit). When `testpat` is high at request acceptance, no PSRAM commands are issued. The block writes `H_RES` pixels at one per cycle with `wr_data = {pix[7:0], line[7:0], pix[7:0]^line[7:0]}`, and otherwise follows the same `busy`/`line_done`/overrun rules.
- Not defined: the `testpat` port and the generator logic are absent, and every line is fetched from PSRAM.

## Test plan
- Reset, then `line_request` with `y_pos=9`, `rd_ack` same cycle, immediate data:
  - Response: 50 commands at `rd_addr = 8000 + 16k`, k = 0..49.
  - 800 writes with `wr_addr` 0..799 in order; a single `line_done`; `overrun_cnt=0`.
- `y_pos=479`: first `rd_addr=FB_BASE=0` (next line wraps to 0).
- `rd_ack` delayed 5 cycles, and `rd_valid` gapped every other cycle:
  - `rd_req` is held for exactly 5 cycles.
  - `wr_en` count is still 16 per burst with no duplicate addresses.
- Three `line_request` pulses during one fetch: one pending line is fetched after `line_done` (address taken from the third pulse's `y_pos`), and `overrun_cnt=1`.
- `rst` asserted at pixel 300, then 4 stray `rd_valid` beats: no `wr_en`, all outputs at reset values, state `IDLE`.
- With `LINE_FETCH_TESTPAT_EN`, `testpat=1`, `y_pos=3`: `rd_req` never rises, and pixel 5 is written with `wr_data=24'h050401`.
